// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the memory stage: access sizes, FSM states,
// the EX/MEM register layout and the alignment rule.
package mem_stage_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_REQ,
    MEM_WAIT
  } mem_state_e;

  typedef struct packed {
    logic             vld;
    logic [XLEN-1:0]  alu_res;
    logic [XLEN-1:0]  din;
    logic             rd;
    logic             wr;
    logic [1:0]       size;
    logic             uns;
    logic [REG_W-1:0] dest;
  } ex_mem_t;

  // Unused size code 3 is treated like a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
    case (size)
      MEM_B:   is_misaligned = 1'b0;
      MEM_H:   is_misaligned = addr[0];
      default: is_misaligned = |addr;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational load/store lane alignment: byte enables, store data replication,
// load lane extraction with sign/zero extension, and misalignment detection.
module lsu_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]      addr,
  input  logic [1:0]      size,
  input  logic            uns,
  input  logic [XLEN-1:0] din,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane  = rdata[{addr, 3'b000} +: 8];
  assign half_lane  = addr[1] ? rdata[31:16] : rdata[15:0];
  assign misaligned = is_misaligned(size, addr);

  always_comb begin
    be        = '0;
    wdata     = '0;
    load_data = '0;
    case (size)
      MEM_B: begin
        be        = 4'b0001 << addr;
        wdata     = {4{din[7:0]}};
        load_data = {{24{~uns & byte_lane[7]}}, byte_lane};
      end
      MEM_H: begin
        be        = addr[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{din[15:0]}};
        load_data = {{16{~uns & half_lane[15]}}, half_lane};
      end
      default: begin
        be        = '1;
        wdata     = din;
        load_data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: EX/MEM pipeline register plus a req/gnt/rvalid data-memory
// sequencer that stalls upstream while a load or store is outstanding.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  EX_alu_res,
  input  logic [XLEN-1:0]  EX_mem_din,
  input  logic             EX_vld,
  input  logic             EX_alu_busy,
  input  logic             EX_mem_rd,
  input  logic             EX_mem_wr,
  input  logic [1:0]       EX_mem_size,
  input  logic             EX_mem_uns,
  input  logic [REG_W-1:0] EX_dest_reg,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [3:0]       dmem_be,
  output logic [XLEN-1:0]  dmem_wdata,
  input  logic             dmem_gnt,
  input  logic             dmem_rvalid,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             MEM_stall,
  output logic             MEM_vld,
  output logic [XLEN-1:0]  MEM_data,
  output logic [REG_W-1:0] MEM_dest_reg,
  output logic             MEM_misaligned
);

  mem_state_e      state, state_nx;
  ex_mem_t         r, cap;
  logic            memop, mis, done, in_req, in_wait, new_mem;
  logic [3:0]      al_be;
  logic [XLEN-1:0] al_wdata, al_load;
  logic            al_mis;

  lsu_align u_align (
    .addr       (r.alu_res[1:0]),
    .size       (r.size),
    .uns        (r.uns),
    .din        (r.din),
    .rdata      (dmem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load),
    .misaligned (al_mis)
  );

  assign cap = '{vld:     EX_vld & ~EX_alu_busy,
                 alu_res: EX_alu_res,
                 din:     EX_mem_din,
                 rd:      EX_mem_rd,
                 wr:      EX_mem_wr,
                 size:    EX_mem_size,
                 uns:     EX_mem_uns,
                 dest:    EX_dest_reg};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= MEM_IDLE;
      r     <= '0;
    end else begin
      state <= state_nx;
      if (!MEM_stall) r <= cap;
    end
  end

  assign in_req  = (state == MEM_REQ);
  assign in_wait = (state == MEM_WAIT);
  assign memop   = r.rd | r.wr;
  assign mis     = r.vld & memop & al_mis;
  assign done    = (in_req & r.wr & dmem_gnt) | (in_wait & dmem_rvalid);
  assign new_mem = cap.vld & (EX_mem_rd | EX_mem_wr)
                 & ~is_misaligned(EX_mem_size, EX_alu_res[1:0]);

  always_comb begin
    state_nx   = state;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_be    = '0;
    dmem_wdata = '0;
    // Any edge that frees the register also decides the next op, so a
    // completing access hands off straight to REQ without an IDLE cycle.
    if (!MEM_stall) begin
      state_nx = new_mem ? MEM_REQ : MEM_IDLE;
    end else if (in_req && dmem_gnt) begin
      state_nx = MEM_WAIT;
    end
    if (in_req) begin
      dmem_req   = 1'b1;
      dmem_we    = r.wr;
      dmem_addr  = {r.alu_res[XLEN-1:2], 2'b00};
      dmem_be    = al_be;
      dmem_wdata = al_wdata;
    end
  end

  assign MEM_stall      = r.vld & memop & ~mis & ~done;
  assign MEM_vld        = r.vld & (~memop | mis | done);
  assign MEM_data       = (MEM_vld & ~mis) ? (r.rd ? al_load : r.alu_res) : '0;
  assign MEM_dest_reg   = r.dest;
  assign MEM_misaligned = mis;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] EX_alu_res, EX_mem_din;
  logic        EX_vld, EX_alu_busy, EX_mem_rd, EX_mem_wr, EX_mem_uns;
  logic [1:0]  EX_mem_size;
  logic [4:0]  EX_dest_reg;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        MEM_stall, MEM_vld, MEM_misaligned;
  logic [31:0] MEM_data;
  logic [4:0]  MEM_dest_reg;

  int tests = 0;
  int fails = 0;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .EX_alu_res(EX_alu_res), .EX_mem_din(EX_mem_din), .EX_vld(EX_vld),
    .EX_alu_busy(EX_alu_busy), .EX_mem_rd(EX_mem_rd), .EX_mem_wr(EX_mem_wr),
    .EX_mem_size(EX_mem_size), .EX_mem_uns(EX_mem_uns), .EX_dest_reg(EX_dest_reg),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .MEM_stall(MEM_stall), .MEM_vld(MEM_vld),
    .MEM_data(MEM_data), .MEM_dest_reg(MEM_dest_reg), .MEM_misaligned(MEM_misaligned)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_idle();
    EX_alu_res = '0; EX_mem_din = '0; EX_vld = 1'b0; EX_alu_busy = 1'b0;
    EX_mem_rd = 1'b0; EX_mem_wr = 1'b0; EX_mem_size = 2'd0; EX_mem_uns = 1'b0;
    EX_dest_reg = '0;
  endtask

  task automatic ex_mem(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] din);
    ex_idle();
    EX_vld = 1'b1; EX_mem_rd = rd; EX_mem_wr = wr; EX_alu_res = addr;
    EX_mem_size = size; EX_mem_uns = uns; EX_mem_din = din; EX_dest_reg = 5'd7;
  endtask

  task automatic test_reset();
    logic [111:0] outs;
    outs = {dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, MEM_stall, MEM_vld,
            MEM_data, MEM_dest_reg, MEM_misaligned};
    tests++;
    if (outs !== '0) begin
      fails++; $display("FAIL reset_outputs: got %h want 0", outs);
    end
  endtask

  task automatic test_alu_op();
    ex_idle();
    EX_vld = 1'b1; EX_alu_res = 32'h1234; EX_dest_reg = 5'd5;
    step();
    ex_idle();
    tests++;
    if ({MEM_vld, MEM_data, MEM_dest_reg, dmem_req, MEM_stall} !== {1'b1, 32'h1234, 5'd5, 1'b0, 1'b0}) begin
      fails++; $display("FAIL alu_op: vld=%b data=%h dest=%0d req=%b stall=%b want 1 00001234 5 0 0",
                        MEM_vld, MEM_data, MEM_dest_reg, dmem_req, MEM_stall);
    end
    step();
    tests++;
    if (MEM_vld !== 1'b0) begin
      fails++; $display("FAIL alu_op_next: MEM_vld got %b want 0", MEM_vld);
    end
  endtask

  task automatic test_store(input string name, input logic [31:0] addr, input logic [1:0] size,
                            input logic [31:0] din, input int gnt_delay,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    ex_mem(1'b0, 1'b1, addr, size, 1'b0, din);
    dmem_gnt = 1'b0;
    step();
    ex_idle();
    for (int i = 0; i < gnt_delay; i++) begin
      tests++;
      if ({MEM_stall, MEM_vld, dmem_req} !== 3'b101) begin
        fails++; $display("FAIL %s_wait: stall/vld/req got %b want 101", name, {MEM_stall, MEM_vld, dmem_req});
      end
      step();
    end
    dmem_gnt = 1'b1;
    #1;
    tests++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !==
        {1'b1, 1'b1, addr[31:2], 2'b00, exp_be, exp_wdata}) begin
      fails++; $display("FAIL %s_bus: req=%b we=%b addr=%h be=%b wdata=%h want 1 1 %h %b %h", name,
                        dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                        {addr[31:2], 2'b00}, exp_be, exp_wdata);
    end
    tests++;
    if ({MEM_stall, MEM_vld, MEM_data} !== {1'b0, 1'b1, addr}) begin
      fails++; $display("FAIL %s_done: stall=%b vld=%b data=%h want 0 1 %h", name,
                        MEM_stall, MEM_vld, MEM_data, addr);
    end
    step();
    dmem_gnt = 1'b0;
    #1;
    tests++;
    if ({dmem_req, MEM_vld} !== 2'b00) begin
      fails++; $display("FAIL %s_after: req/vld got %b want 00", name, {dmem_req, MEM_vld});
    end
  endtask

  task automatic test_load(input string name, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] rdata, input int gnt_delay,
                           input logic [31:0] exp_data);
    int stalls;
    stalls = 0;
    ex_mem(1'b1, 1'b0, addr, size, uns, 32'hFFFF_FFFF);
    dmem_gnt = 1'b0;
    step();
    ex_idle();
    for (int i = 0; i <= gnt_delay; i++) begin
      dmem_gnt = (i == gnt_delay);
      #1;
      if (MEM_stall) stalls++;
      if (i == 0) begin
        tests++;
        if ({dmem_req, dmem_we, dmem_addr} !== {1'b1, 1'b0, addr[31:2], 2'b00}) begin
          fails++; $display("FAIL %s_req: req=%b we=%b addr=%h want 1 0 %h", name,
                            dmem_req, dmem_we, dmem_addr, {addr[31:2], 2'b00});
        end
      end
      step();
    end
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rdata;
    #1;
    tests++;
    if ({MEM_stall, MEM_vld, MEM_data, dmem_req} !== {1'b0, 1'b1, exp_data, 1'b0}) begin
      fails++; $display("FAIL %s_data: stall=%b vld=%b data=%h req=%b want 0 1 %h 0", name,
                        MEM_stall, MEM_vld, MEM_data, dmem_req, exp_data);
    end
    tests++;
    if (stalls != gnt_delay + 1) begin
      fails++; $display("FAIL %s_stalls: got %0d want %0d", name, stalls, gnt_delay + 1);
    end
    step();
    dmem_rvalid = 1'b0;
    #1;
    tests++;
    if (MEM_vld !== 1'b0) begin
      fails++; $display("FAIL %s_after: MEM_vld got %b want 0", name, MEM_vld);
    end
  endtask

  task automatic test_misaligned(input string name, input logic [31:0] addr,
                                 input logic [1:0] size, input logic wr);
    ex_mem(~wr, wr, addr, size, 1'b0, 32'h1234_5678);
    dmem_gnt = 1'b1;
    step();
    ex_idle();
    tests++;
    if ({dmem_req, MEM_misaligned, MEM_vld, MEM_stall, MEM_data} !== {4'b0110, 32'h0}) begin
      fails++; $display("FAIL %s: req=%b mis=%b vld=%b stall=%b data=%h want 0 1 1 0 00000000",
                        name, dmem_req, MEM_misaligned, MEM_vld, MEM_stall, MEM_data);
    end
    step();
    dmem_gnt = 1'b0;
    tests++;
    if ({MEM_misaligned, MEM_vld, dmem_req} !== 3'b000) begin
      fails++; $display("FAIL %s_after: mis/vld/req got %b want 000", name,
                        {MEM_misaligned, MEM_vld, dmem_req});
    end
  endtask

  task automatic test_back_to_back();
    ex_mem(1'b1, 1'b0, 32'h400, 2'd2, 1'b0, 32'h0);
    dmem_gnt = 1'b1;
    step();
    ex_mem(1'b0, 1'b1, 32'h404, 2'd2, 1'b0, 32'hDEAD_BEEF);
    #1;
    tests++;
    if ({dmem_req, dmem_we, MEM_stall} !== 3'b101) begin
      fails++; $display("FAIL b2b_lw_req: req/we/stall got %b want 101", {dmem_req, dmem_we, MEM_stall});
    end
    step();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1122_3344;
    #1;
    tests++;
    if ({MEM_stall, MEM_vld, MEM_data} !== {1'b0, 1'b1, 32'h1122_3344}) begin
      fails++; $display("FAIL b2b_lw_done: stall=%b vld=%b data=%h want 0 1 11223344",
                        MEM_stall, MEM_vld, MEM_data);
    end
    step();
    dmem_rvalid = 1'b0;
    ex_idle();
    #1;
    tests++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, MEM_vld, MEM_data} !==
        {2'b11, 32'h404, 4'hF, 32'hDEAD_BEEF, 1'b1, 32'h404}) begin
      fails++; $display("FAIL b2b_sw: req=%b we=%b addr=%h be=%b wdata=%h vld=%b data=%h want 1 1 00000404 1111 deadbeef 1 00000404",
                        dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, MEM_vld, MEM_data);
    end
    step();
    dmem_gnt = 1'b0;
    tests++;
    if (dmem_req !== 1'b0) begin
      fails++; $display("FAIL b2b_after: req got %b want 0", dmem_req);
    end
  endtask

  task automatic test_reset_mid();
    ex_mem(1'b1, 1'b0, 32'h500, 2'd2, 1'b0, 32'h0);
    dmem_gnt = 1'b1;
    step();
    ex_idle();
    step();
    dmem_gnt = 1'b0;
    #1;
    tests++;
    if ({MEM_stall, dmem_req} !== 2'b10) begin
      fails++; $display("FAIL rst_mid_wait: stall/req got %b want 10", {MEM_stall, dmem_req});
    end
    rst = 1'b0;
    #1;
    test_reset();
    step();
    rst = 1'b1;
    step();
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    #1;
    test_reset();
    step();
    dmem_rvalid = 1'b0;
    test_reset();
    // Multi-cycle EX op still in flight: register captures a bubble.
    ex_idle();
    EX_vld = 1'b1; EX_alu_busy = 1'b1; EX_alu_res = 32'h55; EX_dest_reg = 5'd3;
    step();
    ex_idle();
    tests++;
    if ({MEM_vld, dmem_req} !== 2'b00) begin
      fails++; $display("FAIL busy_bubble: vld/req got %b want 00", {MEM_vld, dmem_req});
    end
  endtask

  initial begin
    rst = 1'b0;
    ex_idle();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    #2;
    test_reset();
    step();
    rst = 1'b1;
    step();
    test_reset();
    test_alu_op();
    test_store("sb_103", 32'h103, 2'd0, 32'h0000_00A5, 0, 4'b1000, 32'hA5A5_A5A5);
    test_store("sh_002", 32'h002, 2'd1, 32'h1234_ABCD, 2, 4'b1100, 32'hABCD_ABCD);
    test_store("sw_010", 32'h010, 2'd2, 32'h0BAD_F00D, 0, 4'b1111, 32'h0BAD_F00D);
    test_load("lh_202", 32'h202, 2'd1, 1'b0, 32'h8001_7FFF, 2, 32'hFFFF_8001);
    test_load("lhu_202", 32'h202, 2'd1, 1'b1, 32'h8001_7FFF, 2, 32'h0000_8001);
    test_load("lb_001", 32'h001, 2'd0, 1'b0, 32'h0000_8000, 0, 32'hFFFF_FF80);
    test_load("lbu_001", 32'h001, 2'd0, 1'b1, 32'h0000_8000, 0, 32'h0000_0080);
    test_load("lh_000", 32'h000, 2'd1, 1'b0, 32'h8001_7FFF, 1, 32'h0000_7FFF);
    test_misaligned("lw_301", 32'h301, 2'd2, 1'b0);
    test_misaligned("sh_001", 32'h001, 2'd1, 1'b1);
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
